// File: rtl/step_fsm_tmr_monitor.sv
// rtl/step_fsm_tmr_monitor.sv - votes triplicated step FSM state, counts events, snapshot readout
module step_fsm_tmr_monitor #(
  parameter int                   IO_SIZE_G       = 3,
  parameter logic [IO_SIZE_G-1:0] IDLE            = '0,
  parameter logic [IO_SIZE_G-1:0] S1_C            = IO_SIZE_G'(3),
  parameter logic [IO_SIZE_G-1:0] S2_C            = IO_SIZE_G'(6),
  parameter logic [IO_SIZE_G-1:0] ERROR           = IO_SIZE_G'(7),
  parameter logic [IO_SIZE_G-1:0] RESET_STATE_G   = IDLE,
  parameter int                   CNT_W           = 16,
  parameter bit                   CLEAR_ON_READ_G = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IO_SIZE_G-1:0] data_a_i,
  input  logic [IO_SIZE_G-1:0] data_b_i,
  input  logic [IO_SIZE_G-1:0] data_c_i,
  output logic [IO_SIZE_G-1:0] state_voted_o,
  output logic [CNT_W-1:0]     seq1_cnt_o,
  output logic [CNT_W-1:0]     seq2_cnt_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     mismatch_cnt_o,
  input  logic                 snap_req_i,
  output logic                 snap_valid_o,
  input  logic                 snap_ready_i,
  output logic [CNT_W-1:0]     snap_seq1_o,
  output logic [CNT_W-1:0]     snap_seq2_o,
  output logic [CNT_W-1:0]     snap_err_o,
  output logic [CNT_W-1:0]     snap_mis_o
);

  typedef enum logic {ST_IDLE, ST_HOLD} rd_state_t;

  // counter index: 0 seq1, 1 seq2, 2 err, 3 mismatch
  logic [IO_SIZE_G-1:0]        r_in_a, r_in_b, r_in_c;
  logic [IO_SIZE_G-1:0]        r_voted;
  logic [IO_SIZE_G-1:0]        w_vote;
  logic                        w_mis;
  logic [3:0]                  w_ev;
  logic [3:0][CNT_W-1:0]       r_cnt;
  logic [3:0][CNT_W-1:0]       w_cnt_nxt;
  logic [3:0][CNT_W-1:0]       r_snap;
  rd_state_t                   r_state, w_state_nxt;
  logic                        w_capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    if (ev && (c != {CNT_W{1'b1}})) return c + 1'b1;
    return c;
  endfunction

  // stage 1: register the three copies as received
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_in_a <= RESET_STATE_G;
      r_in_b <= RESET_STATE_G;
      r_in_c <= RESET_STATE_G;
    end else begin
      r_in_a <= data_a_i;
      r_in_b <= data_b_i;
      r_in_c <= data_c_i;
    end
  end

  // bitwise majority vote and disagreement flag on the stage-1 copies
  always_comb begin
    w_vote = (r_in_a & r_in_b) | (r_in_a & r_in_c) | (r_in_b & r_in_c);
    w_mis  = (r_in_a != r_in_b) | (r_in_a != r_in_c);
  end

  // stage 2: voted state; its current value is the previous state of the incoming vote
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_voted <= RESET_STATE_G;
    else       r_voted <= w_vote;
  end

  assign state_voted_o = r_voted;

  // entry events land on the same edge the voted state updates, so entry is w_vote vs r_voted
  always_comb begin
    w_ev[0] = (w_vote == S1_C)  && (r_voted != S1_C);
    w_ev[1] = (w_vote == S2_C)  && (r_voted != S2_C);
    w_ev[2] = (w_vote == ERROR) && (r_voted != ERROR);
    w_ev[3] = w_mis;
    for (int i = 0; i < 4; i++) w_cnt_nxt[i] = sat_inc(r_cnt[i], w_ev[i]);
  end

  // readout FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // readout FSM next state: capture only from IDLE, release on accept
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snap_req_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (snap_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign snap_valid_o = (r_state == ST_HOLD);

  // counters and snapshot; the snapshot takes the post-event value so a capture-cycle event is kept once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_capture) begin
          r_snap[i] <= w_cnt_nxt[i];
          r_cnt[i]  <= CLEAR_ON_READ_G ? '0 : w_cnt_nxt[i];
        end else begin
          r_cnt[i]  <= w_cnt_nxt[i];
        end
      end
    end
  end

  assign seq1_cnt_o     = r_cnt[0];
  assign seq2_cnt_o     = r_cnt[1];
  assign err_cnt_o      = r_cnt[2];
  assign mismatch_cnt_o = r_cnt[3];
  assign snap_seq1_o    = r_snap[0];
  assign snap_seq2_o    = r_snap[1];
  assign snap_err_o     = r_snap[2];
  assign snap_mis_o     = r_snap[3];

endmodule

// File: tb/tb_step_fsm_tmr_monitor.sv
// tb/tb_step_fsm_tmr_monitor.sv - randomized and directed bench for step_fsm_tmr_monitor
module tb_step_fsm_tmr_monitor;
  localparam int W    = 3;
  localparam int CW   = 4;
  localparam int MAXC = 15;
  localparam int S_IDLE = 0, S1 = 3, S2 = 6, SERR = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  da, db, dc;
  logic          snap_req, snap_ready;
  logic [W-1:0]  voted;
  logic [CW-1:0] c_seq1, c_seq2, c_err, c_mis;
  logic          snap_valid;
  logic [CW-1:0] s_seq1, s_seq2, s_err, s_mis;

  step_fsm_tmr_monitor #(.IO_SIZE_G(W), .CNT_W(CW), .CLEAR_ON_READ_G(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .data_a_i(da), .data_b_i(db), .data_c_i(dc),
    .state_voted_o(voted),
    .seq1_cnt_o(c_seq1), .seq2_cnt_o(c_seq2), .err_cnt_o(c_err), .mismatch_cnt_o(c_mis),
    .snap_req_i(snap_req), .snap_valid_o(snap_valid), .snap_ready_i(snap_ready),
    .snap_seq1_o(s_seq1), .snap_seq2_o(s_seq2), .snap_err_o(s_err), .snap_mis_o(s_mis)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_in[3];
  int m_voted;
  int m_cnt[4];
  int m_snap[4];
  bit m_hold;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // majority by counting ones per bit position
  function automatic int vote3(input int a, input int b, input int c);
    int r = 0;
    for (int k = 0; k < W; k++) begin
      if ((((a >> k) & 1) + ((b >> k) & 1) + ((c >> k) & 1)) >= 2) r += (1 << k);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_in[i] = S_IDLE;
    m_voted = S_IDLE;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
    m_hold = 1'b0;
  endtask

  task automatic compare_all();
    check_val("voted", 32'(voted), 32'(m_voted));
    check_val("seq1_cnt", 32'(c_seq1), 32'(m_cnt[0]));
    check_val("seq2_cnt", 32'(c_seq2), 32'(m_cnt[1]));
    check_val("err_cnt", 32'(c_err), 32'(m_cnt[2]));
    check_val("mis_cnt", 32'(c_mis), 32'(m_cnt[3]));
    check_val("snap_valid", 32'(snap_valid), 32'(m_hold));
    check_val("snap_seq1", 32'(s_seq1), 32'(m_snap[0]));
    check_val("snap_seq2", 32'(s_seq2), 32'(m_snap[1]));
    check_val("snap_err", 32'(s_err), 32'(m_snap[2]));
    check_val("snap_mis", 32'(s_mis), 32'(m_snap[3]));
  endtask

  task automatic step(input int a, input int b, input int c, input bit req, input bit rdy);
    int v, nxt;
    int ev[4];
    bit cap;
    da = W'(a); db = W'(b); dc = W'(c);
    snap_req = req; snap_ready = rdy;
    @(posedge clk); #1;
    v = vote3(m_in[0], m_in[1], m_in[2]);
    ev[0] = (v == S1   && m_voted != S1);
    ev[1] = (v == S2   && m_voted != S2);
    ev[2] = (v == SERR && m_voted != SERR);
    ev[3] = !(m_in[0] == m_in[1] && m_in[1] == m_in[2]);
    cap = !m_hold && req;
    for (int i = 0; i < 4; i++) begin
      nxt = m_cnt[i] + ev[i];
      if (nxt > MAXC) nxt = MAXC;
      if (cap) begin m_snap[i] = nxt; m_cnt[i] = 0; end
      else m_cnt[i] = nxt;
    end
    if (cap) m_hold = 1'b1;
    else if (m_hold && rdy) m_hold = 1'b0;
    m_voted = v;
    m_in[0] = a; m_in[1] = b; m_in[2] = c;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(S_IDLE, S_IDLE, S_IDLE, 1'b0, 1'b0);
  endtask

  // asynchronous reset applied away from the clock edge, checked before any edge
  task automatic do_reset();
    da = S_IDLE; db = S_IDLE; dc = S_IDLE;
    snap_req = 1'b0; snap_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_voted", 32'(voted), S_IDLE);
    check_val("rst_valid", 32'(snap_valid), 0);
    check_val("rst_cnt_or", 32'(c_seq1 | c_seq2 | c_err | c_mis), 0);
    check_val("rst_snap_or", 32'(s_seq1 | s_seq2 | s_err | s_mis), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int r, a, b, c;

  initial begin
    rst = 1'b0;
    da = '0; db = '0; dc = '0;
    snap_req = 1'b0; snap_ready = 1'b0;
    do_reset();

    // 1: S1 sequence
    step(S_IDLE, S_IDLE, S_IDLE, 0, 0);
    step(1, 1, 1, 0, 0);
    step(2, 2, 2, 0, 0);
    step(S1, S1, S1, 0, 0);
    step(S1, S1, S1, 0, 0);
    check_val("t1_seq1", 32'(c_seq1), 1);
    step(S_IDLE, S_IDLE, S_IDLE, 0, 0);
    idle(2);
    check_val("t1_seq1_once", 32'(c_seq1), 1);
    check_val("t1_err", 32'(c_err), 0);
    check_val("t1_mis", 32'(c_mis), 0);

    // 2: single-copy upset
    do_reset();
    for (int i = 0; i < 3; i++) step(2, 2, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(2, 5, 2, 0, 0);
      if (i > 0) check_val("t2_voted", 32'(voted), 2);
    end
    step(2, 2, 2, 0, 0);
    check_val("t2_voted_end", 32'(voted), 2);
    step(2, 2, 2, 0, 0);
    check_val("t2_mis", 32'(c_mis), 3);
    check_val("t2_events", 32'(c_seq1 + c_seq2 + c_err), 0);

    // 3: ERROR saturation then snapshot
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(SERR, SERR, SERR, 0, 0);
      step(S_IDLE, S_IDLE, S_IDLE, 0, 0);
    end
    idle(2);
    check_val("t3_err_sat", 32'(c_err), 15);
    step(S_IDLE, S_IDLE, S_IDLE, 1, 0);
    check_val("t3_snap_err", 32'(s_err), 15);
    check_val("t3_err_clr", 32'(c_err), 0);
    step(S_IDLE, S_IDLE, S_IDLE, 0, 1);

    // 4: held snapshot, ignored second request
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(S2, S2, S2, 0, 0);
      step(S_IDLE, S_IDLE, S_IDLE, 0, 0);
    end
    idle(2);
    step(S_IDLE, S_IDLE, S_IDLE, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(S2, S2, S2, (i == 4), 0);
      check_val("t4_snap_seq2", 32'(s_seq2), 7);
      check_val("t4_valid", 32'(snap_valid), 1);
    end
    step(S_IDLE, S_IDLE, S_IDLE, 1, 1);
    check_val("t4_released", 32'(snap_valid), 0);
    step(S_IDLE, S_IDLE, S_IDLE, 0, 0);
    check_val("t4_no_requeue", 32'(snap_valid), 0);

    // 5: S2 entry coincident with capture
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(S2, S2, S2, 0, 0);
      step(S_IDLE, S_IDLE, S_IDLE, 0, 0);
    end
    idle(1);
    step(S2, S2, S2, 0, 0);
    step(S2, S2, S2, 1, 0);
    check_val("t5_snap_seq2", 32'(s_seq2), 5);
    check_val("t5_seq2_clr", 32'(c_seq2), 0);
    step(S_IDLE, S_IDLE, S_IDLE, 0, 1);
    step(S2, S2, S2, 0, 0);
    idle(2);
    check_val("t5_seq2_next", 32'(c_seq2), 1);

    // 6: reset mid-HOLD and mid-sequence
    step(S_IDLE, S_IDLE, S_IDLE, 1, 0);
    step(1, 1, 1, 0, 0);
    step(S1, S1, S1, 0, 0);
    do_reset();
    idle(4);
    check_val("t6_no_spurious", 32'(c_seq1 + c_seq2 + c_err + c_mis), 0);

    // randomized traffic, including two-copy and three-way splits
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: a = S_IDLE;
        1: a = S1;
        2: a = S2;
        default: a = $urandom_range(0, 7);
      endcase
      b = a; c = a;
      if (r == 0) b = $urandom_range(0, 7);
      else if (r == 1) c = $urandom_range(0, 7);
      else if (r == 2) begin b = $urandom_range(0, 7); c = $urandom_range(0, 7); end
      step(a, b, c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
